// File: rtl/prbs_gen_16b.sv
// prbs_gen_16b: 16-bit parallel PRBS7/15/31 or fixed-pattern word generator
// with seed loading and single-bit error injection on dout[0].
module prbs_gen_16b (
   input  logic        clk_prbs,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [30:0] seed,
   input  logic        load_seed,
   input  logic [15:0] pattern,
   input  logic        inj_err,
   output logic [15:0] dout,
   output logic        dout_valid
);
   logic [30:0] hist, hist_nxt, mask, seed_m;
   logic [15:0] word;
   logic [1:0]  mode_q;
   logic        err_pend;
   logic [22:0] e7;
   logic [30:0] e15;
   logic [46:0] e31;
   // e[i] = b[i-N]: low N bits are the history, upper 16 are this word's bits
   always_comb begin
      e7 = {16'd0, hist[6:0]};
      for (int j = 0; j < 16; j++) e7[7 + j] = e7[j] ^ e7[j + 1];
   end
   always_comb begin
      e15 = {16'd0, hist[14:0]};
      for (int j = 0; j < 16; j++) e15[15 + j] = e15[j] ^ e15[j + 1];
   end
   always_comb begin
      e31 = {16'd0, hist};
      for (int j = 0; j < 16; j++) e31[31 + j] = e31[j] ^ e31[j + 3];
   end
   always_comb begin
      word     = mode == 2'd0 ? e7[22:7] : mode == 2'd1 ? e15[30:15] : mode == 2'd2 ? e31[46:31] : pattern;
      hist_nxt = mode == 2'd0 ? {24'd0, e7[22:16]} : mode == 2'd1 ? {16'd0, e15[30:16]} : mode == 2'd2 ? e31[46:16] : hist;
      mask     = mode == 2'd0 ? 31'h7f : mode == 2'd1 ? 31'h7fff : 31'h7fff_ffff;
      seed_m   = (seed & mask) == 31'd0 ? mask : seed & mask;
   end
   always_ff @(posedge clk_prbs) begin
      if (rst) begin
         hist       <= 31'h7fff_ffff;
         mode_q     <= mode;
         dout       <= 16'd0;
         dout_valid <= 1'b0;
         err_pend   <= 1'b0;
      end else if (load_seed) begin
         hist       <= seed_m;
         dout       <= 16'd0;
         dout_valid <= 1'b0;
         err_pend   <= err_pend | inj_err;
      end else if (mode != mode_q) begin
         hist       <= 31'h7fff_ffff;
         mode_q     <= mode;
         dout_valid <= 1'b0;
         err_pend   <= err_pend | inj_err;
      end else if (en) begin
         hist       <= hist_nxt;
         dout       <= word ^ {15'd0, err_pend | inj_err};
         dout_valid <= 1'b1;
         err_pend   <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         err_pend   <= err_pend | inj_err;
      end
   end
endmodule
